ysyx_24080014_ifu: RTL

YSYX_24080014_IFU -- requirements
Module: ysyx_24080014_ifu

---
 rtl/ysyx_24080014_pkg.sv | 14 +
 rtl/ysyx_24080014_ifu_perf.sv | 30 +++
 rtl/ysyx_24080014_ifu.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ysyx_24080014_pkg.sv
// Shared definitions for the ysyx_24080014 instruction fetch unit.
package ysyx_24080014_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        StAr       = 2'd0,
        StR        = 2'd1,
        StIssue    = 2'd2,
        StWaitNext = 2'd3
    } ifu_state_e;

endpackage

// File: rtl/ysyx_24080014_ifu_perf.sv
// Fetch performance counters: completed R-channel handshakes and cycles spent in AR or R.
// Only instantiated when YSYX_24080014_IFU_PERF_EN is defined.
module ysyx_24080014_ifu_perf
    import ysyx_24080014_pkg::*;
(
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            fetch_fire,
    input  logic            stall,
    output logic [XLEN-1:0] perf_fetch_cnt,
    output logic [XLEN-1:0] perf_stall_cnt
);

    logic [XLEN-1:0] fetch_cnt_q;
    logic [XLEN-1:0] stall_cnt_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (fetch_fire) fetch_cnt_q <= fetch_cnt_q + 1'b1;
            if (stall)      stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;

endmodule

// File: rtl/ysyx_24080014_ifu.sv
// Instruction fetch unit: AXI4-Lite read master, one instruction in flight.
// Define YSYX_24080014_IFU_PERF_EN to add the perf_fetch_cnt/perf_stall_cnt outputs.
module ysyx_24080014_ifu
    import ysyx_24080014_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            aclk,
    input  logic            aresetn,
    output logic            arvalid,
    input  logic            arready,
    output logic [XLEN-1:0] araddr,
    input  logic            rvalid,
    output logic            rready,
    input  logic [XLEN-1:0] rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    input  logic            next_valid,
    output logic            next_ready,
    input  logic [XLEN-1:0] next_pc
`ifdef YSYX_24080014_IFU_PERF_EN
    ,
    output logic [XLEN-1:0] perf_fetch_cnt,
    output logic [XLEN-1:0] perf_stall_cnt
`endif
);

    localparam logic [XLEN-1:0] AlignMask = {{(XLEN-2){1'b1}}, 2'b00};

    ifu_state_e      state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inst_q;
    logic            arvalid_q;
    logic            rready_q;
    logic            out_valid_q;
    logic            next_ready_q;

    // Handshake flags are registered alongside the state so every output comes straight
    // from a flop; arvalid stays low while in reset and rises on the first edge after.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= StAr;
            pc_q         <= RESET_PC & AlignMask;
            inst_q       <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            next_ready_q <= 1'b0;
        end else begin
            case (state_q)
                StAr: begin
                    if (arvalid_q && arready) begin
                        state_q   <= StR;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end else begin
                        arvalid_q <= 1'b1;
                    end
                end
                StR: begin
                    if (rready_q && rvalid) begin
                        state_q     <= StIssue;
                        inst_q      <= rdata;
                        rready_q    <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                StIssue: begin
                    if (out_valid_q && out_ready) begin
                        state_q      <= StWaitNext;
                        out_valid_q  <= 1'b0;
                        next_ready_q <= 1'b1;
                    end
                end
                StWaitNext: begin
                    if (next_ready_q && next_valid) begin
                        state_q      <= StAr;
                        pc_q         <= next_pc & AlignMask;
                        next_ready_q <= 1'b0;
                        arvalid_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= StAr;
                    arvalid_q    <= 1'b0;
                    rready_q     <= 1'b0;
                    out_valid_q  <= 1'b0;
                    next_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign arvalid    = arvalid_q;
    assign araddr     = pc_q & AlignMask;
    assign rready     = rready_q;
    assign out_valid  = out_valid_q;
    assign out_inst   = inst_q;
    assign out_pc     = pc_q;
    assign next_ready = next_ready_q;

`ifdef YSYX_24080014_IFU_PERF_EN
    logic fetch_fire;
    logic stall;

    assign fetch_fire = rready_q && rvalid;
    assign stall      = (state_q == StAr) || (state_q == StR);

    ysyx_24080014_ifu_perf u_perf (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .fetch_fire     (fetch_fire),
        .stall          (stall),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );
`endif

endmodule
